// File: rtl/tgate_link_ctrl.sv
// tgate_link_ctrl: drive-side controller for a CMOS transmission-gate link.
// It generates complementary gate controls for an external switch and owns a
// local tri-state driver onto pad. The switch and the driver are never enabled
// together. Every change of mode passes through a dead gap of DEAD_CYCLES
// cycles in which both are off.
// Optional feature: define TGATE_TIMEOUT_EN to force a release after MAX_HOLD
// cycles in LINK or DRIVE. The timed-out request then stays locked out until
// it has dropped for at least one cycle.
module tgate_link_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEAD_CYCLES = 2,
  parameter int MAX_HOLD    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_link,
  input  logic             req_drive,
  input  logic [WIDTH-1:0] drv_data,
  inout  wire  [WIDTH-1:0] pad,
  output logic             control,
  output logic             control_n,
  output logic             drive_en,
  output logic             link_ack,
  output logic             drive_ack,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             timeout
);

  // The gap counter is loaded with DEAD_CYCLES-1 and counts down to zero.
  localparam int GAP_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GAP   = 2'd1,
    ST_LINK  = 2'd2,
    ST_DRIVE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  // Registered outputs. Each one is decoded from the next state, so it changes
  // on the same edge as the state itself.
  logic             control_q, control_d;
  logic             control_n_q, control_n_d;
  logic             drive_en_q, drive_en_d;
  logic             link_ack_q, link_ack_d;
  logic             drive_ack_q, drive_ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] drv_q, drv_d;

  // Read path: a two-flop stage on pad, then capture while the link is closed.
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]       link_cnt_q, link_cnt_d;
  logic             rd_valid_q, rd_valid_d;

  // Requests after any lockout, plus the forced-release hooks.
  logic req_link_eff, req_drive_eff;
  logic hold_expired;
  logic timeout_fire;

`ifdef TGATE_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              lock_link_q, lock_link_d;
  logic              lock_drive_q, lock_drive_d;
  logic              timeout_q, timeout_d;

  assign req_link_eff  = req_link  & ~lock_link_q;
  assign req_drive_eff = req_drive & ~lock_drive_q;
  assign hold_expired  = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  assign timeout       = timeout_q;

  // Hold counter, lockout flags and the timeout pulse, computed from the
  // current and next state.
  always_comb begin
    hold_cnt_d   = '0;
    lock_link_d  = lock_link_q & req_link;
    lock_drive_d = lock_drive_q & req_drive;
    timeout_d    = timeout_fire;
    if ((state_d == ST_LINK) || (state_d == ST_DRIVE)) begin
      hold_cnt_d = (state_q == state_d) ? hold_cnt_q + 1'b1 : HOLD_W'(1);
    end
    if (timeout_fire && (state_q == ST_LINK)) begin
      lock_link_d = 1'b1;
    end
    if (timeout_fire && (state_q == ST_DRIVE)) begin
      lock_drive_d = 1'b1;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      lock_link_q  <= 1'b0;
      lock_drive_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      lock_link_q  <= lock_link_d;
      lock_drive_q <= lock_drive_d;
      timeout_q    <= timeout_d;
    end
  end
`else
  assign req_link_eff  = req_link;
  assign req_drive_eff = req_drive;
  assign hold_expired  = 1'b0;
  assign timeout       = 1'b0;
  // This build does not need MAX_HOLD or the forced-release strobe.
  // Referencing them here keeps the build free of unused-object warnings.
  wire unused_timeout_cfg = (MAX_HOLD > 0) | timeout_fire;
`endif

  // Next-state logic: every exit from LINK or DRIVE goes through GAP, and the
  // requests are re-examined only when the gap expires.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    timeout_fire = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (req_drive_eff || req_link_eff) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          if (req_drive_eff) begin
            state_d = ST_DRIVE;
          end else if (req_link_eff) begin
            state_d = ST_LINK;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      ST_LINK: begin
        // A drive request preempts an open link.
        if (!req_link_eff || req_drive_eff) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (hold_expired) begin
          state_d      = ST_GAP;
          gap_cnt_d    = GAP_LOAD;
          timeout_fire = 1'b1;
        end
      end
      ST_DRIVE: begin
        // A link request is ignored until the drive request drops.
        if (!req_drive_eff) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (hold_expired) begin
          state_d      = ST_GAP;
          gap_cnt_d    = GAP_LOAD;
          timeout_fire = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Output and read-path decode from the next state.
  always_comb begin
    control_d   = (state_d == ST_LINK);
    control_n_d = ~control_d;
    drive_en_d  = (state_d == ST_DRIVE);
    link_ack_d  = control_d;
    drive_ack_d = drive_en_d;
    busy_d      = (state_d != ST_OFF);
    drv_d       = drive_en_d ? drv_data : drv_q;
    // rd_data follows the sync chain while the link is closed. The first
    // samples were taken before the gate closed, so rd_valid waits until the
    // link has stayed closed for three edges.
    rd_data_d   = (state_q == ST_LINK) ? sync2_q : rd_data_q;
    link_cnt_d  = '0;
    if ((state_d == ST_LINK) && (state_q == ST_LINK)) begin
      link_cnt_d = (link_cnt_q == 2'd3) ? 2'd3 : link_cnt_q + 2'd1;
    end
    rd_valid_d  = (state_d == ST_LINK) && (link_cnt_d == 2'd3);
  end

  // State and gap counter. Reset opens the switch immediately and skips the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_q   <= 1'b0;
      control_n_q <= 1'b1;
      drive_en_q  <= 1'b0;
      link_ack_q  <= 1'b0;
      drive_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      drv_q       <= '0;
    end else begin
      control_q   <= control_d;
      control_n_q <= control_n_d;
      drive_en_q  <= drive_en_d;
      link_ack_q  <= link_ack_d;
      drive_ack_q <= drive_ack_d;
      busy_q      <= busy_d;
      drv_q       <= drv_d;
    end
  end

  // Pad synchroniser and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      rd_data_q  <= '0;
      link_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sync1_q    <= pad;
      sync2_q    <= sync1_q;
      rd_data_q  <= rd_data_d;
      link_cnt_q <= link_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign pad       = drive_en_q ? drv_q : {WIDTH{1'bz}};
  assign control   = control_q;
  assign control_n = control_n_q;
  assign drive_en  = drive_en_q;
  assign link_ack  = link_ack_q;
  assign drive_ack = drive_ack_q;
  assign busy      = busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_tgate_link_ctrl.sv
// Testbench for tgate_link_ctrl. A behavioural model follows the ownership rules:
// who holds the pad, how much of the dead gap is left, and the lockouts.
// That model produces the expected value of every output on every cycle.
// Directed sequences cover the listed scenarios; randomized requests follow.
module tb_tgate_link_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEAD     = 2;
  localparam int MAX_HOLD = 4;
`ifdef TGATE_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  localparam int M_NONE  = 0;
  localparam int M_LINK  = 1;
  localparam int M_DRIVE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_link = 1'b0;
  logic             req_drive = 1'b0;
  logic [WIDTH-1:0] drv_data = '0;
  logic [WIDTH-1:0] far_val = '0;
  wire  [WIDTH-1:0] pad;
  logic             control, control_n, drive_en, link_ack, drive_ack, busy;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Far side of the transmission gate: it reaches pad only while control is high.
  assign pad = control ? far_val : {WIDTH{1'bz}};

  always #5 clk = ~clk;

  tgate_link_ctrl #(
    .WIDTH(WIDTH), .DEAD_CYCLES(DEAD), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_link(req_link), .req_drive(req_drive),
    .drv_data(drv_data), .pad(pad), .control(control), .control_n(control_n),
    .drive_en(drive_en), .link_ack(link_ack), .drive_ack(drive_ack), .busy(busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .timeout(timeout)
  );

  // ---------------- reference model ----------------
  int               owner, gap_left, held, link_age;
  bit               lock_l, lock_d, m_timeout;
  logic [WIDTH-1:0] m_drv, m_rd, p1, p2;
  bit               m_rd_ok, p1_ok, p2_ok;

  function automatic bit exp_link();
    return (owner == M_LINK) && (gap_left == 0);
  endfunction

  function automatic bit exp_drive();
    return (owner == M_DRIVE) && (gap_left == 0);
  endfunction

  task automatic model_reset();
    owner = M_NONE; gap_left = 0; held = 0; link_age = 0;
    lock_l = 0; lock_d = 0; m_timeout = 0;
    m_drv = '0; m_rd = '0; p1 = '0; p2 = '0;
    m_rd_ok = 1; p1_ok = 1; p2_ok = 1;
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_step();
    bit               eff_l, eff_d, nl, nd, want, was_link, was_drive;
    logic [WIDTH-1:0] pad_now;
    was_link  = exp_link();
    was_drive = exp_drive();
    pad_now   = was_link ? far_val : m_drv;
    if (was_link) begin
      m_rd = p2; m_rd_ok = p2_ok;
    end
    p2 = p1; p2_ok = p1_ok;
    p1 = pad_now; p1_ok = was_link || was_drive;
    eff_l = req_link && !lock_l;
    eff_d = req_drive && !lock_d;
    nl = lock_l && req_link;
    nd = lock_d && req_drive;
    m_timeout = 0;
    if (gap_left > 0) begin
      gap_left--;
      if (gap_left == 0) begin
        owner    = eff_d ? M_DRIVE : (eff_l ? M_LINK : M_NONE);
        held     = 1;
        link_age = 0;
      end
    end else if (owner == M_NONE) begin
      if (eff_l || eff_d) gap_left = DEAD;
    end else begin
      want = (owner == M_LINK) ? (eff_l && !eff_d) : eff_d;
      if (!want) begin
        owner = M_NONE; gap_left = DEAD;
      end else if (TO_ON && held == MAX_HOLD) begin
        m_timeout = 1;
        if (owner == M_LINK) nl = 1; else nd = 1;
        owner = M_NONE; gap_left = DEAD;
      end else begin
        held++;
        if (link_age < 3) link_age++;
      end
    end
    lock_l = nl; lock_d = nd;
    if (exp_drive()) m_drv = drv_data;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    check_eq("control",   control,   exp_link());
    check_eq("control_n", control_n, !exp_link());
    check_eq("drive_en",  drive_en,  exp_drive());
    check_eq("link_ack",  link_ack,  exp_link());
    check_eq("drive_ack", drive_ack, exp_drive());
    check_eq("busy",      busy,      (owner != M_NONE) || (gap_left > 0));
    check_eq("rd_valid",  rd_valid,  exp_link() && (link_age >= 3));
    check_eq("timeout",   timeout,   m_timeout);
    check_eq("exclusive", control & drive_en, 1'b0);
    if (m_rd_ok) check_eq("rd_data", rd_data, m_rd);
    if (exp_drive()) check_eq("pad_drive", pad, m_drv);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic settle();
    req_link = 0; req_drive = 0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  // Tick until the selected ack rises; returns the tick count, or -1 on timeout.
  task automatic wait_ack(input bit want_drive, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((want_drive ? drive_ack : link_ack) && lat < 0) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int lat, cnt_a, cnt_b;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1;

    // Link request from OFF: ack after DEAD+1 edges, valid read data three edges later.
    far_val = 8'hA5; req_link = 1;
    wait_ack(1'b0, lat);
    check_eq("link_latency", lat, DEAD + 1);
    repeat (3) tick();
    check_eq("t2_rd_valid", rd_valid, 1'b1);
    check_eq("t2_rd_data", rd_data, 8'hA5);
    req_link = 0;
    tick();
    check_eq("t2_control_drop", control, 1'b0);
    settle();

    // A drive request preempts an open link.
    req_link = 1;
    wait_ack(1'b0, lat);
    req_drive = 1; drv_data = 8'h3C;
    tick();
    check_eq("t3_control_open", control, 1'b0);
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (drive_en) begin
        lat = i;
        break;
      end
    end
    check_eq("t3_drive_latency", lat, DEAD + 1);
    check_eq("t3_pad", pad, 8'h3C);
    settle();

    // Simultaneous requests: drive wins, then the link follows after a gap.
    req_link = 1; req_drive = 1; drv_data = 8'h5A;
    wait_ack(1'b1, lat);
    check_eq("t4_drive_wins", lat, DEAD + 1);
    check_eq("t4_no_link", link_ack, 1'b0);
    req_drive = 0;
    wait_ack(1'b0, lat);
    check_eq("t4_link_after", lat, DEAD + 1);
    settle();

    // A one-cycle pulse: the gap runs out with no request, so no grant.
    req_link = 1;
    tick();
    req_link = 0;
    cnt_a = (busy ? 1 : 0); cnt_b = (link_ack ? 1 : 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt_a += (busy ? 1 : 0);
      cnt_b += (link_ack ? 1 : 0);
    end
    check_eq("t5_busy_cycles", cnt_a, DEAD);
    check_eq("t5_no_ack", cnt_b, 0);
    settle();

`ifdef TGATE_TIMEOUT_EN
    // A held drive is forced off after MAX_HOLD cycles and stays locked out.
    req_drive = 1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      drv_data = WIDTH'($urandom);
      tick();
      cnt_a += (drive_en ? 1 : 0);
      cnt_b += (timeout ? 1 : 0);
    end
    check_eq("t6_drive_cycles", cnt_a, MAX_HOLD);
    check_eq("t6_timeout_pulses", cnt_b, 1);
    req_drive = 0;
    tick();
    req_drive = 1;
    wait_ack(1'b1, lat);
    check_eq("t6_regrant", lat, DEAD + 1);
    settle();
`endif

    // Asynchronous reset in the middle of DRIVE.
    req_drive = 1; drv_data = 8'hC3;
    wait_ack(1'b1, lat);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_eq("rst_drive_en", drive_en, 1'b0);
    check_eq("rst_control_n", control_n, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    req_drive = 0;
    @(negedge clk);
    rst_n = 1;
    tick();

    // Randomized traffic with persistent request levels.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req_link = ~req_link;
      if ($urandom_range(0, 7) == 0) req_drive = ~req_drive;
      drv_data = WIDTH'($urandom);
      far_val  = WIDTH'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
